// File: rtl/nspi_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nspi_rx : multi-channel SPI receiver, oversampled by clk, one word per channel
// Revision 1.0
// ---------------------------------------------------------------------------
module nspi_rx #(
   parameter int CHANNEL_NUMBER = 3,
   parameter int SPI_SIZE       = 8,
   parameter bit MSB_FIRST      = 1'b1,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable,
   input  logic                      spi_clk,
   input  logic [CHANNEL_NUMBER-1:0] spi_mosi,
   output logic [SPI_SIZE-1:0]       data_out [CHANNEL_NUMBER-1:0],
   output logic                      data_valid,
   output logic                      frame_error,
   output logic                      busy
);

   localparam int CW = $clog2(SPI_SIZE);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(SPI_SIZE - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      RECEIVE = 1'b1
   } state_t;

   state_t state, state_next;

   logic s1, s2, s3;
   logic [CHANNEL_NUMBER-1:0] m1, m2;
   logic spi_edge;

   logic [CW-1:0] bit_cnt;
   logic [CW-1:0] idx;
   logic [TW-1:0] to_cnt;
   logic [SPI_SIZE-1:0] shreg     [CHANNEL_NUMBER-1:0];
   logic [SPI_SIZE-1:0] word_next [CHANNEL_NUMBER-1:0];

   logic capture, done, tmo;

   // spi_clk sync resets high so a clock held high across reset release is not an edge
   always_ff @(posedge clk) begin
      if (!rst) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
         s3 <= 1'b1;
         m1 <= '0;
         m2 <= '0;
      end else begin
         s1 <= spi_clk;
         s2 <= s1;
         s3 <= s2;
         m1 <= spi_mosi;
         m2 <= m1;
      end
   end

   assign spi_edge = s2 & ~s3;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      capture    = 1'b0;
      done       = 1'b0;
      tmo        = 1'b0;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            if (enable && spi_edge) begin
               capture    = 1'b1;
               state_next = RECEIVE;
            end
         end
         RECEIVE: begin
            busy = 1'b1;
            if (!enable) begin
               state_next = IDLE;
            end else if (spi_edge) begin
               // an edge takes priority over a coincident timeout expiry
               capture = 1'b1;
               if (bit_cnt == LAST_BIT) begin
                  done       = 1'b1;
                  state_next = IDLE;
               end
            end else if (to_cnt == TMO_LAST) begin
               tmo        = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      idx = MSB_FIRST ? (LAST_BIT - bit_cnt) : bit_cnt;
      for (int c = 0; c < CHANNEL_NUMBER; c++) begin
         word_next[c]      = shreg[c];
         word_next[c][idx] = m2[c];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         bit_cnt     <= '0;
         to_cnt      <= '0;
         data_valid  <= 1'b0;
         frame_error <= 1'b0;
         for (int c = 0; c < CHANNEL_NUMBER; c++) begin
            shreg[c]    <= '0;
            data_out[c] <= '0;
         end
      end else begin
         data_valid  <= done;
         frame_error <= tmo;
         for (int c = 0; c < CHANNEL_NUMBER; c++) begin
            if (capture) begin
               shreg[c] <= word_next[c];
            end
            if (done) begin
               data_out[c] <= word_next[c];
            end
         end
         if (state_next == IDLE) begin
            bit_cnt <= '0;
         end else if (capture) begin
            bit_cnt <= bit_cnt + 1'b1;
         end
         // saturating so a stalled link can never wrap back below the limit
         if (capture || state_next == IDLE) begin
            to_cnt <= '0;
         end else if (to_cnt != TMO_MAX) begin
            to_cnt <= to_cnt + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_nspi_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_nspi_rx : directed self-checking bench for nspi_rx
// ---------------------------------------------------------------------------
module tb_nspi_rx;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       enable = 1'b1;
   logic       sclk8 = 1'b0;
   logic [2:0] mosi8 = 3'b000;
   logic       sclk16 = 1'b0;
   logic [0:0] mosi16 = 1'b0;

   logic [7:0]  dout8 [2:0];
   logic        dv8, fe8, busy8;
   logic [15:0] doutl [0:0];
   logic        dvl, fel, busyl;
   logic [15:0] doutm [0:0];
   logic        dvm, fem, busym;

   int cyc = 0;
   int checks = 0;
   int failures = 0;
   int dv_cnt = 0;
   int fe_cnt = 0;
   int dv_cyc = 0;
   int dv_prev_cyc = 0;
   int fe_cyc = 0;
   int last_rise = 0;
   logic [7:0] dv_d = 8'h00;
   logic [7:0] dv_prev_d = 8'h00;

   nspi_rx dut (
      .clk(clk), .rst(rst), .enable(enable), .spi_clk(sclk8), .spi_mosi(mosi8),
      .data_out(dout8), .data_valid(dv8), .frame_error(fe8), .busy(busy8)
   );

   nspi_rx #(.CHANNEL_NUMBER(1), .SPI_SIZE(16), .MSB_FIRST(1'b0), .TIMEOUT_CYCLES(64)) dut_l16 (
      .clk(clk), .rst(rst), .enable(enable), .spi_clk(sclk16), .spi_mosi(mosi16),
      .data_out(doutl), .data_valid(dvl), .frame_error(fel), .busy(busyl)
   );

   nspi_rx #(.CHANNEL_NUMBER(1), .SPI_SIZE(16), .MSB_FIRST(1'b1), .TIMEOUT_CYCLES(64)) dut_m16 (
      .clk(clk), .rst(rst), .enable(enable), .spi_clk(sclk16), .spi_mosi(mosi16),
      .data_out(doutm), .data_valid(dvm), .frame_error(fem), .busy(busym)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (dv8) begin
         dv_cnt++;
         dv_prev_cyc = dv_cyc;
         dv_cyc = cyc;
         dv_prev_d = dv_d;
         dv_d = dout8[0];
      end
      if (fe8) begin
         fe_cnt++;
         fe_cyc = cyc;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drives nedges bits of a size-bit word; bus 0 = 8-bit DUT, bus 1 = 16-bit DUTs
   task automatic send(input bit bus, input int size, input int nedges,
                       input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                       input bit msbf, input int half);
      for (int i = 0; i < nedges; i++) begin
         int b;
         b = msbf ? (size - 1 - i) : i;
         if (bus == 1'b0) begin
            mosi8 = {w2[b], w1[b], w0[b]};
            sclk8 = 1'b0;
         end else begin
            mosi16[0] = w0[b];
            sclk16 = 1'b0;
         end
         tick(half);
         if (bus == 1'b0) sclk8 = 1'b1;
         else sclk16 = 1'b1;
         last_rise = cyc + 1;
         tick(half);
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      tick(3);
      checks++; if (dout8[0] !== 8'h00 || dout8[1] !== 8'h00 || dout8[2] !== 8'h00) begin failures++; $display("FAIL reset_data: got %h %h %h expected 00 00 00", dout8[2], dout8[1], dout8[0]); end
      checks++; if (dv8 !== 1'b0 || fe8 !== 1'b0) begin failures++; $display("FAIL reset_strobes: got dv=%b fe=%b expected 0 0", dv8, fe8); end
      checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy8); end
      checks++; if (doutl[0] !== 16'h0000 || doutm[0] !== 16'h0000) begin failures++; $display("FAIL reset_data16: got %h %h expected 0000 0000", doutl[0], doutm[0]); end
      rst = 1'b1;
      tick(2);
   endtask

   task automatic test_basic;
      int dv0;
      int fe0;
      dv0 = dv_cnt;
      fe0 = fe_cnt;
      send(1'b0, 8, 8, 16'hA5, 16'h3C, 16'hFF, 1'b1, 4);
      tick(4);
      checks++; if (dv_cnt - dv0 !== 1) begin failures++; $display("FAIL basic_dv_count: got %0d expected 1", dv_cnt - dv0); end
      checks++; if (dv_cyc !== last_rise + 2) begin failures++; $display("FAIL basic_latency: got cycle %0d expected %0d", dv_cyc, last_rise + 2); end
      checks++; if (dout8[0] !== 8'hA5 || dout8[1] !== 8'h3C || dout8[2] !== 8'hFF) begin failures++; $display("FAIL basic_data: got %h %h %h expected ff 3c a5", dout8[2], dout8[1], dout8[0]); end
      checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL basic_busy: got %b expected 0", busy8); end
      checks++; if (fe_cnt !== fe0) begin failures++; $display("FAIL basic_fe: got %0d expected %0d", fe_cnt, fe0); end
   endtask

   task automatic test_bit_order;
      send(1'b1, 16, 16, 16'h8001, 16'h0, 16'h0, 1'b0, 4);
      tick(4);
      checks++; if (doutl[0] !== 16'h8001) begin failures++; $display("FAIL order_lsb_8001: got %h expected 8001", doutl[0]); end
      checks++; if (doutm[0] !== 16'h8001) begin failures++; $display("FAIL order_msb_8001: got %h expected 8001", doutm[0]); end
      send(1'b1, 16, 16, 16'h1234, 16'h0, 16'h0, 1'b0, 4);
      tick(4);
      checks++; if (doutl[0] !== 16'h1234) begin failures++; $display("FAIL order_lsb_1234: got %h expected 1234", doutl[0]); end
      checks++; if (doutm[0] !== 16'h2C48) begin failures++; $display("FAIL order_msb_1234: got %h expected 2c48", doutm[0]); end
   endtask

   task automatic test_timeout;
      int dv0;
      int fe0;
      dv0 = dv_cnt;
      fe0 = fe_cnt;
      send(1'b0, 8, 5, 16'h00, 16'hFF, 16'h55, 1'b1, 4);
      tick(80);
      checks++; if (fe_cnt - fe0 !== 1) begin failures++; $display("FAIL timeout_fe_count: got %0d expected 1", fe_cnt - fe0); end
      checks++; if (fe_cyc !== last_rise + 66) begin failures++; $display("FAIL timeout_fe_time: got cycle %0d expected %0d", fe_cyc, last_rise + 66); end
      checks++; if (dv_cnt !== dv0) begin failures++; $display("FAIL timeout_no_dv: got %0d expected %0d", dv_cnt, dv0); end
      checks++; if (dout8[0] !== 8'hA5 || dout8[1] !== 8'h3C || dout8[2] !== 8'hFF) begin failures++; $display("FAIL timeout_data_held: got %h %h %h expected ff 3c a5", dout8[2], dout8[1], dout8[0]); end
      checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL timeout_busy: got %b expected 0", busy8); end
      send(1'b0, 8, 8, 16'h81, 16'h81, 16'h81, 1'b1, 4);
      tick(4);
      checks++; if (dout8[0] !== 8'h81 || dout8[2] !== 8'h81) begin failures++; $display("FAIL timeout_next_word: got %h %h expected 81 81", dout8[2], dout8[0]); end
   endtask

   task automatic test_back_to_back;
      int dv0;
      dv0 = dv_cnt;
      send(1'b0, 8, 8, 16'h12, 16'h12, 16'h12, 1'b1, 2);
      send(1'b0, 8, 8, 16'h34, 16'h34, 16'h34, 1'b1, 2);
      tick(4);
      checks++; if (dv_cnt - dv0 !== 2) begin failures++; $display("FAIL b2b_dv_count: got %0d expected 2", dv_cnt - dv0); end
      checks++; if (dv_cyc - dv_prev_cyc !== 32) begin failures++; $display("FAIL b2b_spacing: got %0d expected 32", dv_cyc - dv_prev_cyc); end
      checks++; if (dv_prev_d !== 8'h12 || dv_d !== 8'h34) begin failures++; $display("FAIL b2b_data: got %h then %h expected 12 then 34", dv_prev_d, dv_d); end
   endtask

   task automatic test_reset_mid_word;
      int dv0;
      int fe0;
      send(1'b0, 8, 4, 16'hFF, 16'hFF, 16'hFF, 1'b1, 4);
      rst = 1'b0;
      tick(1);
      checks++; if (dout8[0] !== 8'h00 || dout8[1] !== 8'h00 || dout8[2] !== 8'h00) begin failures++; $display("FAIL midrst_data: got %h %h %h expected 00 00 00", dout8[2], dout8[1], dout8[0]); end
      checks++; if (busy8 !== 1'b0 || dv8 !== 1'b0 || fe8 !== 1'b0) begin failures++; $display("FAIL midrst_flags: got busy=%b dv=%b fe=%b expected 0 0 0", busy8, dv8, fe8); end
      rst = 1'b1;
      dv0 = dv_cnt;
      fe0 = fe_cnt;
      tick(2);
      send(1'b0, 8, 8, 16'h5A, 16'h5A, 16'h5A, 1'b1, 4);
      tick(80);
      checks++; if (dv_cnt - dv0 !== 1) begin failures++; $display("FAIL midrst_dv_count: got %0d expected 1", dv_cnt - dv0); end
      checks++; if (dout8[0] !== 8'h5A) begin failures++; $display("FAIL midrst_word: got %h expected 5a", dout8[0]); end
      checks++; if (fe_cnt !== fe0) begin failures++; $display("FAIL midrst_no_fe: got %0d expected %0d", fe_cnt, fe0); end
   endtask

   task automatic test_enable_and_high_release;
      int dv0;
      dv0 = dv_cnt;
      sclk8 = 1'b1;
      rst = 1'b0;
      tick(2);
      rst = 1'b1;
      tick(6);
      checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL hirel_busy: got %b expected 0", busy8); end
      checks++; if (dv_cnt !== dv0) begin failures++; $display("FAIL hirel_dv: got %0d expected %0d", dv_cnt, dv0); end
      enable = 1'b0;
      send(1'b0, 8, 8, 16'hC3, 16'hC3, 16'hC3, 1'b1, 4);
      tick(4);
      checks++; if (dv_cnt !== dv0 || busy8 !== 1'b0) begin failures++; $display("FAIL disabled_ignored: got dv_count=%0d busy=%b expected %0d 0", dv_cnt, busy8, dv0); end
      checks++; if (dout8[0] !== 8'h00) begin failures++; $display("FAIL disabled_data: got %h expected 00", dout8[0]); end
      enable = 1'b1;
      tick(2);
      send(1'b0, 8, 8, 16'hC3, 16'hC3, 16'hC3, 1'b1, 4);
      tick(4);
      checks++; if (dv_cnt - dv0 !== 1) begin failures++; $display("FAIL enabled_dv_count: got %0d expected 1", dv_cnt - dv0); end
      checks++; if (dout8[0] !== 8'hC3 || dout8[1] !== 8'hC3) begin failures++; $display("FAIL enabled_word: got %h %h expected c3 c3", dout8[1], dout8[0]); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_bit_order;
      test_timeout;
      test_back_to_back;
      test_reset_mid_word;
      test_enable_and_high_release;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/nspi_rx.md
Name: nspi_rx

Overview:
Multi-channel SPI receiver. It deserialises CHANNEL_NUMBER parallel MOSI lines that share one SPI clock, which is the link format driven by the matrix-side nspi transmitter. The block oversamples spi_clk and spi_mosi with the system clock, captures one bit per spi_clk rising edge, and presents a parallel word per channel with a one-cycle valid strobe. It is used for loopback verification of the transmitter on the FPGA and as the input stage of downstream matrix receivers.

Parameters:
CHANNEL_NUMBER, 3, number of parallel MOSI lines (1..16)
SPI_SIZE, 8, bits per word (8 or 16)
MSB_FIRST, 1, 1 = first received bit is data MSB; 0 = first received bit is data LSB
TIMEOUT_CYCLES, 64, clk cycles without an spi_clk rising edge after which a partial word is discarded (>= 4)

Ports:
clk  input  1  system clock; must run >= 4x the spi_clk frequency
rst  input  1  reset, synchronous, active-low (rst = 0 resets on the next clk rising edge)
enable  input  1  receive enable; when 0, edges are ignored
spi_clk  input  1  asynchronous SPI clock; idle low; data valid at its rising edge
spi_mosi  input  CHANNEL_NUMBER  asynchronous data lines, one per channel
data_out  output  SPI_SIZE x CHANNEL_NUMBER (unpacked array [CHANNEL_NUMBER-1:0] of [SPI_SIZE-1:0])  last complete word per channel
data_valid  output  1  one-cycle strobe; data_out updated this cycle
frame_error  output  1  one-cycle strobe; partial word discarded on timeout
busy  output  1  high while a word is partially received

Behaviour:
- Synchronisation: spi_clk passes through 2 flops (s1, s2) plus a history flop (s3). spi_mosi passes through 2 flops per channel so it stays aligned with s2. Rising edge is s2 & ~s3.
- Reset (rst = 0): data_out all 0, data_valid 0, frame_error 0, busy 0, bit counter 0, timeout counter 0, state IDLE. The spi_clk s1/s2/s3 flops reset to 1 and the mosi sync flops reset to 0. As a result, spi_clk held high through reset release produces no edge; its next low-to-high transition does.
- Input timing: spi_clk high and low phases must each last >= 2 clk cycles. mosi must be stable for >= 2 clk cycles around each spi_clk rising edge.
- Shift register: SPI_SIZE bits per channel. Each edge stores the synchronised mosi bit at index bit_cnt. With MSB_FIRST = 1, the bit lands at data bit SPI_SIZE-1-bit_cnt; with MSB_FIRST = 0, it lands at data bit bit_cnt.
- State IDLE: busy = 0. On an edge with enable = 1: store bit 0, bit_cnt <= 1, timeout counter <= 0, go to RECEIVE. If SPI_SIZE would be 1, this is illegal and not supported.
- State RECEIVE: busy = 1. On an edge, store the bit, bit_cnt++, and reset the timeout counter.
  - When the stored bit is the last one (bit_cnt == SPI_SIZE-1), then on that same clk edge: data_out <= completed words (including the new bit), data_valid <= 1 for one cycle, bit_cnt <= 0, state IDLE.
  - Without an edge, the timeout counter increments. When it reaches TIMEOUT_CYCLES: frame_error <= 1 for one cycle, discard the partial word, bit_cnt <= 0, state IDLE, data_out unchanged.
- Latency: the pin spi_clk is first sampled high at clk edge E0; the capture and data_valid both occur at edge E2 (data_valid visible during the cycle after E2).
- Back-to-back words: the first edge of the next word can occur at the spi_clk period following the last edge; it is accepted from IDLE in the same way.
- Simultaneous edge and timeout expiry in the same cycle: the edge wins, the bit is stored, and there is no frame_error.
- enable deasserted in RECEIVE: discard the partial word, go to IDLE, no frame_error. data_out is held.
- data_out holds its value until the next completed word. data_valid and frame_error are never high in the same cycle.
- Widths: bit_cnt is $clog2(SPI_SIZE) bits. The timeout counter is $clog2(TIMEOUT_CYCLES+1) bits and saturates, so it never wraps.

Test Plan:
1. Defaults, spi_clk period 8 clk, send ch0 = 0xA5, ch1 = 0x3C, ch2 = 0xFF MSB first -> exactly one data_valid pulse, 2 clk edges after the 8th spi_clk rise is sampled; data_out = {0xA5, 0x3C, 0xFF}; busy low afterwards.
2. MSB_FIRST = 0, SPI_SIZE = 16, send 0x8001 with bit0 first -> data_out[0] = 0x8001; with MSB_FIRST = 1 the same bit stream yields 0x8001 bit-reversed = 0x8001 (palindrome). Check 0x1234 as well -> 0x2C48 under MSB_FIRST = 1.
3. 5 edges then silence -> frame_error is a single pulse exactly 64 clk after the 5th capture; no data_valid; data_out unchanged. A following word 0x81 is received correctly.
4. Two words 0x12 then 0x34 with no gap (period 4 clk, minimum legal) -> two data_valid pulses 32 clk apart; data_out goes 0x12 then 0x34.
5. rst = 0 for one cycle after 4 bits -> all outputs 0 next cycle; a following full word 0x5A gives data_valid with 0x5A and no frame_error.
6. spi_clk held high across reset release, and enable = 0 during one full word -> no spurious capture and no data_valid. After enable = 1, the next word 0xC3 is received correctly.
